// File: rtl/bitnet_layer_sequencer.sv
// Walks the layer chain forward (and optionally backward), issuing start strobes and waiting for per-layer done pulses.
// Registered outputs: the strobe appears the cycle after start or after the previous layer's done; a per-layer watchdog ends a stalled pass with err.
module bitnet_layer_sequencer #(
  parameter int LAYERS  = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                                          clk_in,
  input  logic                                          rst_in,
  input  logic                                          start,
  input  logic                                          train,
  input  logic [LAYERS-1:0]                             fd_done,
  input  logic [LAYERS-1:0]                             bk_done,
  output logic [LAYERS-1:0]                             fd_prop,
  output logic [LAYERS-1:0]                             bk_prop,
  output logic                                          busy,
  output logic                                          phase,
  output logic [((LAYERS > 1) ? $clog2(LAYERS) : 1)-1:0] layer_idx,
  output logic                                          done,
  output logic                                          err
);

  localparam int IW = (LAYERS > 1) ? $clog2(LAYERS) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [IW-1:0] IDX_LAST = IW'(LAYERS - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_SAT  = CW'(TIMEOUT);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_FD_ISSUE = 3'd1;
  localparam logic [2:0] S_FD_WAIT  = 3'd2;
  localparam logic [2:0] S_BK_ISSUE = 3'd3;
  localparam logic [2:0] S_BK_WAIT  = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  logic [2:0]    state, state_n;
  logic [IW-1:0] idx_n;
  logic          phase_n;
  logic          train_q, train_n;
  logic [CW-1:0] wait_cnt, cnt_n;
  logic          err_n;

  always_comb begin
    state_n = state;
    idx_n   = layer_idx;
    phase_n = phase;
    train_n = train_q;
    cnt_n   = wait_cnt;
    err_n   = err;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_FD_ISSUE;
          train_n = train;
          err_n   = 1'b0;
          idx_n   = '0;
          phase_n = 1'b0;
        end
      end
      S_FD_ISSUE: begin
        state_n = S_FD_WAIT;
        cnt_n   = '0;
      end
      S_FD_WAIT: begin
        // A done in the same cycle as the last watchdog count takes priority.
        if (fd_done[layer_idx]) begin
          if (layer_idx != IDX_LAST) begin
            idx_n   = layer_idx + 1'b1;
            state_n = S_FD_ISSUE;
          end else if (train_q) begin
            idx_n   = IDX_LAST;
            phase_n = 1'b1;
            state_n = S_BK_ISSUE;
          end else begin
            state_n = S_DONE;
          end
        end else if (wait_cnt == CNT_LAST) begin
          err_n   = 1'b1;
          state_n = S_DONE;
        end else if (wait_cnt != CNT_SAT) begin
          cnt_n = wait_cnt + 1'b1;
        end
      end
      S_BK_ISSUE: begin
        state_n = S_BK_WAIT;
        cnt_n   = '0;
      end
      S_BK_WAIT: begin
        if (bk_done[layer_idx]) begin
          if (layer_idx != '0) begin
            idx_n   = layer_idx - 1'b1;
            state_n = S_BK_ISSUE;
          end else begin
            state_n = S_DONE;
          end
        end else if (wait_cnt == CNT_LAST) begin
          err_n   = 1'b1;
          state_n = S_DONE;
        end else if (wait_cnt != CNT_SAT) begin
          cnt_n = wait_cnt + 1'b1;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
        idx_n   = '0;
        phase_n = 1'b0;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state they describe.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state     <= S_IDLE;
      layer_idx <= '0;
      phase     <= 1'b0;
      train_q   <= 1'b0;
      wait_cnt  <= '0;
      err       <= 1'b0;
      fd_prop   <= '0;
      bk_prop   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      layer_idx <= idx_n;
      phase     <= phase_n;
      train_q   <= train_n;
      wait_cnt  <= cnt_n;
      err       <= err_n;
      fd_prop   <= (state_n == S_FD_ISSUE) ? (LAYERS'(1) << idx_n) : '0;
      bk_prop   <= (state_n == S_BK_ISSUE) ? (LAYERS'(1) << idx_n) : '0;
      busy      <= (state_n != S_IDLE);
      done      <= (state_n == S_DONE);
    end
  end

endmodule

// File: tb/tb_bitnet_layer_sequencer.sv
// Bench for bitnet_layer_sequencer: a timeline of expected outputs is planned per pass from the timing rules, then compared every cycle.
module tb_bitnet_layer_sequencer;

  localparam int L    = 4;
  localparam int TO   = 8;
  localparam int MAXC = 5000;
  localparam int NL   = 16;

  logic       clk_in = 1'b0;
  logic       rst_in, start, train;
  logic [3:0] fd_done, bk_done, fd_prop, bk_prop;
  logic       busy, phase, done, err;
  logic [1:0] layer_idx;

  bitnet_layer_sequencer #(.LAYERS(L), .TIMEOUT(TO)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .start(start), .train(train),
    .fd_done(fd_done), .bk_done(bk_done), .fd_prop(fd_prop), .bk_prop(bk_prop),
    .busy(busy), .phase(phase), .layer_idx(layer_idx), .done(done), .err(err)
  );

  always #5 clk_in = ~clk_in;

  // Stimulus per cycle
  logic       drv_rst[MAXC], drv_start[MAXC], drv_train[MAXC];
  logic [3:0] drv_fd[MAXC], drv_bk[MAXC];
  // Expected outputs per cycle
  logic [3:0] exp_fd[MAXC], exp_bk[MAXC];
  logic       exp_busy[MAXC], exp_done[MAXC], exp_err[MAXC], exp_phase[MAXC];
  logic [1:0] exp_idx[MAXC];
  // Hand-computed pins: cycle, selector (0 fd,1 bk,2 done,3 err,4 busy,5 phase), value
  int lit_c[NL], lit_s[NL], lit_v[NL];

  int cyc = 0;
  bit ready = 0;
  int n_tests = 0, n_fail = 0;

  task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", nm, c, act, exp);
    end
  endtask

  function automatic logic [3:0] noise(input int m);
    logic [3:0] v;
    v = 4'(($urandom));
    return (m == 0) ? 4'b0000 : (m == 1) ? v : 4'b1111;
  endfunction

  // One pass: forward steps 0..L-1, then backward steps L..2L-1 (layer 2L-1-s).
  // dly[s]=0 means that layer never answers; otherwise its done arrives dly[s] cycles after its strobe.
  task automatic plan_pass(input int c0, input bit trn, input int dly[8], input int nmode,
                           input int bstart, input int ab_step, input int ab_off, output int nxt);
    int t, d, tend, lyr, r, e, nsteps;
    bit bk, to, stop;
    logic [3:0] b1;
    r = -1; to = 0; stop = 0; t = c0 + 1;
    drv_start[c0] = 1'b1;
    drv_train[c0] = trn;
    drv_fd[c0] = noise(nmode);
    drv_bk[c0] = noise(nmode);
    nsteps = trn ? 2 * L : L;
    for (int s = 0; s < nsteps && !stop; s++) begin
      bk  = (s >= L);
      lyr = bk ? (2 * L - 1 - s) : s;
      b1  = 4'(1 << lyr);
      if (s == ab_step) r = t + ab_off;
      d    = dly[s];
      tend = (d == 0) ? t + TO : t + d;
      if (bk) exp_bk[t] = b1; else exp_fd[t] = b1;
      for (int c = t; c <= tend; c++) begin
        exp_busy[c]  = 1'b1;
        exp_phase[c] = bk;
        exp_idx[c]   = 2'(lyr);
        drv_fd[c]    = noise(nmode);
        drv_bk[c]    = noise(nmode);
        if (c > t) begin
          if (c == tend && d != 0) begin
            if (bk) drv_bk[c] = drv_bk[c] | b1; else drv_fd[c] = drv_fd[c] | b1;
          end else begin
            if (bk) drv_bk[c] = drv_bk[c] & ~b1; else drv_fd[c] = drv_fd[c] & ~b1;
          end
        end
      end
      t = tend + 1;
      if (d == 0) begin
        to = 1;
        stop = 1;
      end
    end
    e = t;
    exp_busy[e]  = 1'b1;
    exp_done[e]  = 1'b1;
    exp_phase[e] = exp_phase[e-1];
    exp_idx[e]   = exp_idx[e-1];
    drv_fd[e] = noise(nmode);
    drv_bk[e] = noise(nmode);
    for (int c = c0 + 1; c < MAXC; c++) exp_err[c] = (to && c >= e);
    if (bstart >= 0) drv_start[bstart] = 1'b1;
    if (r >= 0) begin
      drv_rst[r] = 1'b1;
      for (int c = r + 1; c <= e; c++) begin
        exp_fd[c] = '0; exp_bk[c] = '0; exp_busy[c] = 0; exp_done[c] = 0;
        exp_phase[c] = 0; exp_idx[c] = '0;
      end
      for (int c = r + 1; c < MAXC; c++) exp_err[c] = 1'b0;
      nxt = r + 1;
    end else begin
      nxt = e + 1;
    end
  endtask

  task automatic apply(input int c);
    rst_in  = drv_rst[c];
    start   = drv_start[c];
    train   = drv_train[c];
    fd_done = drv_fd[c];
    bk_done = drv_bk[c];
  endtask

  initial begin
    int d[8];
    int nxt, c0, rr;
    bit trn;
    for (int c = 0; c < MAXC; c++) begin
      drv_rst[c] = 0; drv_start[c] = 0; drv_train[c] = 1'($urandom);
      drv_fd[c] = '0; drv_bk[c] = '0;
      exp_fd[c] = '0; exp_bk[c] = '0; exp_busy[c] = 0; exp_done[c] = 0;
      exp_err[c] = 0; exp_phase[c] = 0; exp_idx[c] = '0;
    end
    for (int c = 0; c < 3; c++) drv_rst[c] = 1'b1;

    // A: forward only, D=1
    d = '{1, 1, 1, 1, 1, 1, 1, 1};
    plan_pass(5, 0, d, 0, -1, -1, 0, nxt);
    // B: training pass, D=3
    d = '{3, 3, 3, 3, 3, 3, 3, 3};
    plan_pass(15, 1, d, 0, -1, -1, 0, nxt);
    // C: layer 2 stalls, plus a start pulse while busy
    d = '{1, 1, 0, 1, 1, 1, 1, 1};
    plan_pass(50, 0, d, 0, 58, -1, 0, nxt);
    // D: every done bit high every cycle
    d = '{1, 1, 1, 1, 1, 1, 1, 1};
    plan_pass(65, 0, d, 2, -1, -1, 0, nxt);
    // E: dones landing exactly on the last watchdog count
    d = '{TO, 1, TO, 1, 1, TO, 1, TO};
    plan_pass(75, 1, d, 1, 90, -1, 0, nxt);
    // F: reset while waiting on backward layer 1
    d = '{2, 2, 2, 2, 2, 2, 0, 2};
    plan_pass(121, 1, d, 1, -1, 6, 2, nxt);
    // G: fresh start right after reset
    d = '{1, 2, 3, 4, 5, 6, 7, 8};
    plan_pass(143, 0, d, 0, -1, -1, 0, nxt);

    c0 = nxt + 1;
    while (c0 < MAXC - 200) begin
      trn = 1'($urandom);
      for (int s = 0; s < 8; s++) begin
        rr = $urandom % 12;
        d[s] = (rr == 0) ? 0 : (rr < 3) ? TO : $urandom_range(1, TO);
      end
      plan_pass(c0, trn, d, $urandom % 3, ($urandom % 2 == 0) ? c0 + 2 + ($urandom % 8) : -1, -1, 0, nxt);
      c0 = nxt + ($urandom % 3);
    end

    lit_c = '{6, 12, 14, 15, 32, 32, 44, 48, 64, 64, 66, 72, 120, 120, 143, 144};
    lit_s = '{0, 0, 2, 4, 1, 5, 1, 2, 3, 2, 3, 0, 2, 3, 4, 0};
    lit_v = '{1, 8, 1, 0, 8, 1, 1, 1, 1, 1, 0, 8, 1, 0, 0, 1};

    apply(0);
    ready = 1;
    while (cyc < MAXC - 1) begin
      @(posedge clk_in);
      #1;
      cyc++;
      apply(cyc);
    end
    @(negedge clk_in);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  always @(negedge clk_in) begin
    if (ready && cyc >= 1 && cyc < MAXC) begin
      chk("fd_prop", cyc, 32'(fd_prop), 32'(exp_fd[cyc]));
      chk("bk_prop", cyc, 32'(bk_prop), 32'(exp_bk[cyc]));
      chk("busy", cyc, 32'(busy), 32'(exp_busy[cyc]));
      chk("done", cyc, 32'(done), 32'(exp_done[cyc]));
      chk("err", cyc, 32'(err), 32'(exp_err[cyc]));
      if (exp_busy[cyc]) chk("phase", cyc, 32'(phase), 32'(exp_phase[cyc]));
      if (exp_busy[cyc] && !exp_done[cyc]) chk("layer_idx", cyc, 32'(layer_idx), 32'(exp_idx[cyc]));
      for (int k = 0; k < NL; k++) begin
        if (lit_c[k] == cyc) begin
          case (lit_s[k])
            0: chk("pin_fd_prop", cyc, 32'(fd_prop), 32'(lit_v[k]));
            1: chk("pin_bk_prop", cyc, 32'(bk_prop), 32'(lit_v[k]));
            2: chk("pin_done", cyc, 32'(done), 32'(lit_v[k]));
            3: chk("pin_err", cyc, 32'(err), 32'(lit_v[k]));
            4: chk("pin_busy", cyc, 32'(busy), 32'(lit_v[k]));
            default: chk("pin_phase", cyc, 32'(phase), 32'(lit_v[k]));
          endcase
        end
      end
    end
  end

endmodule

// File: doc/bitnet_layer_sequencer.md
# bitnet_layer_sequencer

Sequences forward and backward propagation across a chain of `LAYERS` bitnet layer blocks (down3-style reducers and similar). Each layer has a one-cycle `fd_prop`/`bk_prop` start strobe and a one-cycle `*_prop_done` completion pulse. The sequencer starts layer 0 forward, waits for its done pulse, then advances to the next layer. When `train` is set, it then runs backward from layer `LAYERS-1` down to 0. It sits between the top-level training/inference controller and the layer stack, and adds a per-layer timeout watchdog.

## Interface
- `LAYERS`, 4, number of layers in the chain (>=1)
- `TIMEOUT`, 64, max cycles to wait for one layer's done pulse (>=2)

- `clk_in`  in  1  system clock
- `rst_in`  in  1  synchronous, active-high reset
- `start`  in  1  request one pass; sampled only in IDLE
- `train`  in  1  sampled with `start`; 1 = forward then backward, 0 = forward only
- `fd_done`  in  LAYERS  per-layer forward-done pulses (bit i = layer i)
- `bk_done`  in  LAYERS  per-layer backward-done pulses
- `fd_prop`  out  LAYERS  one-hot, one-cycle forward start strobe
- `bk_prop`  out  LAYERS  one-hot, one-cycle backward start strobe
- `busy`  out  1  high from the cycle after accepted `start` through the `done` cycle
- `phase`  out  1  0 = forward, 1 = backward (valid while busy)
- `layer_idx`  out  max(1,$clog2(LAYERS))  layer currently active
- `done`  out  1  one-cycle pulse at end of pass (normal or timeout)
- `err`  out  1  sticky timeout flag; cleared on next accepted `start`

## Operation
- States:
  - IDLE -> FD_ISSUE on `start`; latch `train`, clear `err`, set `layer_idx`=0.
  - FD_ISSUE: assert `fd_prop[layer_idx]` for 1 cycle, then -> FD_WAIT.
  - FD_WAIT: on `fd_done[layer_idx]`:
    - if `layer_idx`<LAYERS-1: increment `layer_idx`, -> FD_ISSUE;
    - else if latched `train`: `layer_idx`=LAYERS-1, `phase`=1, -> BK_ISSUE;
    - else -> DONE.
  - BK_ISSUE / BK_WAIT: mirror of the forward states using `bk_prop`/`bk_done`. `layer_idx` decrements; after layer 0 completes -> DONE.
  - DONE: `done`=1 for 1 cycle, -> IDLE.
- Only the done bit of the active layer in the active phase is honoured. Done bits for other layers, and any done in an ISSUE state, are ignored.
- Timeout: a wait counter clears on entry to FD_WAIT/BK_WAIT and increments each WAIT cycle. If it reaches TIMEOUT-1 with no matching done, set `err`=1 and -> DONE. A done arriving in that same cycle wins and no error is raised.
- Counter width is $clog2(TIMEOUT+1). It saturates and never wraps.
- `start` while busy is ignored. `train` changes mid-pass have no effect.
- Reset (including mid-pass): state IDLE, all outputs 0 (`fd_prop`, `bk_prop`, `busy`, `phase`, `layer_idx`, `done`, `err`). No strobe is emitted in the reset cycle or the cycle after it.
- LAYERS=1: `layer_idx` is tied 0, and forward goes directly to BK_ISSUE/DONE.

## Timing
- All outputs are registered.
- Accepted `start` at cycle 0 → `fd_prop[0]` at cycle 1.
- If every layer returns done D cycles after its strobe (D>=1):
  - `fd_prop[i]` at cycle 1+i(D+1);
  - forward-only `done` at cycle LAYERS(D+1)+1;
  - training pass `done` at cycle 2·LAYERS(D+1)+1, with the first `bk_prop[LAYERS-1]` at cycle LAYERS(D+1)+1.
- Timeout: strobe at cycle k with no done → `done`=1 and `err`=1 at cycle k+TIMEOUT+1.
- `busy` falls the cycle after `done`. A new `start` is accepted in the first IDLE cycle.
- At most one bit of `fd_prop | bk_prop` is high in any cycle.

## Test plan
- LAYERS=4, D=1, `train`=0, `start` at cycle 0 → `fd_prop` = 0001, 0010, 0100, 1000 at cycles 1, 3, 5, 7; `done` at cycle 9; `bk_prop` never asserted; `err`=0.
- LAYERS=4, D=3, `train`=1 → forward strobes at cycles 1, 5, 9, 13; `bk_prop` = 1000, 0100, 0010, 0001 at cycles 17, 21, 25, 29; `done` at cycle 33; `phase`=1 from cycle 17.
- TIMEOUT=8; layer 2 never returns done → `fd_prop[2]` at cycle k; `done` and `err` high at k+9; layer 3 never strobed; next `start` clears `err`.
- Spurious `fd_done`=1111 every cycle from cycle 0 → only the active layer advances; strobes at cycles 1, 3, 5, 7 (done seen in the first WAIT cycle).
- Assert `rst_in` in BK_WAIT of layer 1 → next cycle all outputs 0, state IDLE; a fresh `start` gives `fd_prop[0]` one cycle later.
- `start` pulsed while busy, and done arriving exactly at wait count TIMEOUT-1 → busy `start` ignored; the pass completes with `err`=0.
